// File: rtl/mem_pkg.sv
// Shared constants and types for the two-port memory arbiter.
// Read tags travel alongside RAM reads so returns can be steered to the right port.
package mem_pkg;

    localparam int WORD_SIZE = 16;
    localparam int ADDR_SIZE = 8;
    localparam int MEM_DEPTH = 1 << ADDR_SIZE;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_e;

    typedef struct packed {
        logic     valid;
        port_id_e port;
    } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the favoured port when both request
// and flips to the other port after every grant.
module rr_arb2 import mem_pkg::*; (
    input  logic clka,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic ptr
);

    port_id_e ptr_q;
    port_id_e ptr_d;

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Grants are suppressed while reset is held so nothing is accepted into a clearing pipeline.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        ptr_d = ptr_q;
        if (rst) begin
            if (req0 && (!req1 || ptr_q == PORT0)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        if (gnt0) begin
            ptr_d = PORT1;
        end else if (gnt1) begin
            ptr_d = PORT0;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between a write-fill port (0) and a read-out port (1),
// registering the granted access onto the RAM and steering read data back with a per-port strobe.
module mem_port_arbiter import mem_pkg::*; #(
    parameter int WORD_SIZE   = mem_pkg::WORD_SIZE,
    parameter int ADDR_SIZE   = mem_pkg::ADDR_SIZE,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clka,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [WORD_SIZE-1:0] din0,
    output logic                 gnt0,
    output logic                 rvalid0,
    output logic [WORD_SIZE-1:0] rdata0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0] din1,
    output logic                 gnt1,
    output logic                 rvalid1,
    output logic [WORD_SIZE-1:0] rdata1,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_din,
    input  logic [WORD_SIZE-1:0] mem_dout,
    output logic                 arb_ptr
);

    // Handshake: a requester raises reqX with weX/addrX/dinX stable and holds them until it
    // sees gntX; the access is accepted in the cycle where reqX && gntX, and dropping reqX
    // before a grant simply withdraws the request.

    logic                 acc;
    port_id_e             sel;
    logic                 sel_we;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [WORD_SIZE-1:0] sel_din;

    rr_arb2 u_arb (
        .clka (clka),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .ptr  (arb_ptr)
    );

    assign acc      = gnt0 | gnt1;
    assign sel      = gnt1 ? PORT1 : PORT0;
    assign sel_we   = gnt1 ? we1   : we0;
    assign sel_addr = gnt1 ? addr1 : addr0;
    assign sel_din  = gnt1 ? din1  : din0;

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            mem_en <= acc;
            mem_we <= acc & sel_we;
            if (acc) begin
                mem_addr <= sel_addr;
                mem_din  <= sel_din;
            end
        end
    end

    // Stage k is live in the cycle k after mem_en, so the last stage lines up with douta.
    rd_tag_t [MEM_LATENCY:0] tag_q;
    rd_tag_t                 ret;

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= '{valid: acc & ~sel_we, port: sel};
            for (int i = 1; i <= MEM_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign ret     = tag_q[MEM_LATENCY];
    assign rvalid0 = ret.valid && (ret.port == PORT0);
    assign rvalid1 = ret.valid && (ret.port == PORT1);

    // Returned data passes straight through on the strobe cycle and is held in a register afterwards.
    logic [WORD_SIZE-1:0] rdata0_q;
    logic [WORD_SIZE-1:0] rdata1_q;

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvalid0) begin
                rdata0_q <= mem_dout;
            end
            if (rvalid1) begin
                rdata1_q <= mem_dout;
            end
        end
    end

    assign rdata0 = rvalid0 ? mem_dout : rdata0_q;
    assign rdata1 = rvalid1 ? mem_dout : rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (read latency 1 and 3) share one stimulus
// stream, each with its own RAM model; read returns are scored against an expected queue.
module tb_mem_port_arbiter;

    logic        clka;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] din0, din1;

    logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, mem_en_a, mem_we_a, ptr_a;
    logic [15:0] rdata0_a, rdata1_a, mem_din_a, mem_dout_a;
    logic [7:0]  mem_addr_a;
    logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_en_b, mem_we_b, ptr_b;
    logic [15:0] rdata0_b, rdata1_b, mem_din_b, mem_dout_b;
    logic [7:0]  mem_addr_b;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int obs_g0 = 0;
    int obs_g1 = 0;

    // entry = {due cycle[31:0], port, data[15:0]}
    logic [48:0] exp1_q[$];
    logic [48:0] exp3_q[$];

    logic        pend_en, pend_we;
    logic [7:0]  pend_addr;
    logic [15:0] pend_din;

    // ---------------- clock / reset ----------------
    initial clka = 1'b0;
    always #5 clka = ~clka;
    always @(posedge clka) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
        .clka(clka), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .din0(din0),
        .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
        .req1(req1), .we1(we1), .addr1(addr1), .din1(din1),
        .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_din(mem_din_a), .mem_dout(mem_dout_a), .arb_ptr(ptr_a)
    );

    mem_port_arbiter #(.MEM_LATENCY(3)) dut3 (
        .clka(clka), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .din0(din0),
        .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
        .req1(req1), .we1(we1), .addr1(addr1), .din1(din1),
        .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_din(mem_din_b), .mem_dout(mem_dout_b), .arb_ptr(ptr_b)
    );

    // ---------------- RAM models ----------------
    logic [15:0] ram1 [256];
    logic [15:0] ram3 [256];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [3];

    always @(posedge clka) begin
        if (mem_en_a) begin
            if (mem_we_a) ram1[mem_addr_a] <= mem_din_a;
            else          pipe1 <= ram1[mem_addr_a];
        end
    end
    assign mem_dout_a = pipe1;

    always @(posedge clka) begin
        if (mem_en_b) begin
            if (mem_we_b) ram3[mem_addr_b] <= mem_din_b;
            else          pipe3[0] <= ram3[mem_addr_b];
        end
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_dout_b = pipe3[2];

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int d, input logic rv0, input logic rv1,
                       input logic [15:0] rd0, input logic [15:0] rd1);
        logic [48:0] e;
        logic        have;
        logic        due_now;
        string       sfx;
        e    = '0;
        sfx  = (d == 0) ? "_l1" : "_l3";
        have = (d == 0) ? (exp1_q.size() != 0) : (exp3_q.size() != 0);
        if (have) e = (d == 0) ? exp1_q[0] : exp3_q[0];
        due_now = have && (e[48:17] <= cyc);
        if (rv0 || rv1) chk({"rvalid_onehot", sfx}, rv0 & rv1, 1'b0);
        if (rv0 || rv1 || due_now) begin
            chk({"rvalid_timing", sfx}, rv0 | rv1, have && (e[48:17] == cyc));
            if (have) begin
                if (d == 0) void'(exp1_q.pop_front());
                else        void'(exp3_q.pop_front());
                if (rv0 || rv1) begin
                    chk({"rvalid_port", sfx}, rv1, e[16]);
                    chk({"rdata", sfx}, rv1 ? rd1 : rd0, e[15:0]);
                end
            end
        end
    endtask

    always @(negedge clka) begin
        mon(0, rvalid0_a, rvalid1_a, rdata0_a, rdata1_a);
        mon(1, rvalid0_b, rvalid1_b, rdata0_b, rdata1_b);
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [15:0] d1);
        @(posedge clka);
        #1;
        req0 = r0; we0 = w0; addr0 = a0; din0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; din1 = d1;
    endtask

    // Checks grants for this cycle and the memory issue of the previous cycle, then records
    // what this cycle's accept should produce.
    task automatic step(input logic eg0, input logic eg1, input logic [15:0] erd);
        @(negedge clka);
        chk("gnt0_l1", gnt0_a, eg0);
        chk("gnt1_l1", gnt1_a, eg1);
        chk("gnt0_l3", gnt0_b, eg0);
        chk("gnt1_l3", gnt1_b, eg1);
        chk("mem_en_l1", mem_en_a, pend_en);
        chk("mem_en_l3", mem_en_b, pend_en);
        chk("mem_we_l1", mem_we_a, pend_en & pend_we);
        chk("mem_we_l3", mem_we_b, pend_en & pend_we);
        if (pend_en) begin
            chk("mem_addr_l1", mem_addr_a, pend_addr);
            chk("mem_addr_l3", mem_addr_b, pend_addr);
            chk("mem_din_l1", mem_din_a, pend_din);
        end
        obs_g0 += int'(gnt0_a);
        obs_g1 += int'(gnt1_a);
        if (eg0 || eg1) begin
            pend_we   = eg1 ? we1   : we0;
            pend_addr = eg1 ? addr1 : addr0;
            pend_din  = eg1 ? din1  : din0;
            if (!pend_we) begin
                exp1_q.push_back({32'(cyc + 2), eg1, erd});
                exp3_q.push_back({32'(cyc + 4), eg1, erd});
            end
        end
        pend_en = eg0 | eg1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
            step(0, 0, 16'h0000);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; din0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; din1 = 0;
        pend_en = 0; pend_we = 0; pend_addr = 0; pend_din = 0;

        // Reset held two cycles with a request pending: nothing may be granted or issued.
        for (int k = 0; k < 2; k++) begin
            @(posedge clka);
            #1;
            req0 = 1; we0 = 1; addr0 = 8'h44; din0 = 16'h4444;
            @(negedge clka);
            chk("rst_gnt0", gnt0_a, 1'b0);
            chk("rst_mem_en", mem_en_a, 1'b0);
            chk("rst_mem_we", mem_we_a, 1'b0);
            chk("rst_rvalid0", rvalid0_a, 1'b0);
            chk("rst_rvalid1", rvalid1_b, 1'b0);
        end
        @(posedge clka);
        #1;
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; din0 = 0;
        step(0, 0, 16'h0000);
        chk("idle_mem_addr", mem_addr_a, 8'h00);
        chk("idle_mem_din", mem_din_a, 16'h0000);
        chk("idle_rdata0", rdata0_a, 16'h0000);
        chk("idle_rdata1", rdata1_b, 16'h0000);
        chk("idle_ptr", ptr_a, 1'b0);
        idle(1);

        // Port 0 fill, one write per cycle.
        for (int i = 0; i < 256; i++) begin
            drive(1, 1, 8'(i), 16'h1000 + 16'(i), 0, 0, 8'h00, 16'h0000);
            step(1, 0, 16'h0000);
        end

        // Port 1 readback straight after the fill; returns must be gap-free and in order.
        for (int i = 0; i < 256; i++) begin
            drive(0, 0, 8'h00, 16'h0000, 1, 0, 8'(i), 16'h0000);
            step(0, 1, 16'h1000 + 16'(i));
            if (i == 0) chk("ptr_after_fill", ptr_a, 1'b1);
        end
        idle(6);
        chk("ptr_after_readback", ptr_a, 1'b0);

        // Contention: alternate grants starting at port 0; first read sees the fresh write.
        obs_g0 = 0;
        obs_g1 = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1, 1, 8'h10, 16'hBEEF, 1, 0, 8'h10, 16'h0000);
            step(k % 2 == 0, k % 2 == 1, 16'hBEEF);
        end
        chk("contention_g0_count", obs_g0, 5);
        chk("contention_g1_count", obs_g1, 5);

        // Lone port 0 read returns on rvalid0 and leaves the pointer at port 1.
        drive(1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000);
        step(1, 0, 16'hBEEF);
        idle(6);
        chk("ptr_after_p0_read", ptr_b, 1'b1);

        // Three reads on port 1, one port 0 write, then a one-cycle reset while reads are in flight.
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 8'h00, 16'h0000, 1, 0, 8'(i), 16'h0000);
            step(0, 1, 16'h1000 + 16'(i));
        end
        drive(1, 1, 8'h20, 16'h5555, 0, 0, 8'h00, 16'h0000);
        step(1, 0, 16'h0000);
        @(posedge clka);
        #1;
        rst = 1'b0;
        req0 = 1; we0 = 0; addr0 = 8'h07; din0 = 0;
        req1 = 1; we1 = 0; addr1 = 8'h05; din1 = 0;
        exp1_q.delete();
        exp3_q.delete();
        pend_en = 0;
        @(negedge clka);
        chk("midrst_gnt0", gnt0_a, 1'b0);
        chk("midrst_gnt1", gnt1_a, 1'b0);
        chk("midrst_mem_en", mem_en_a, 1'b0);
        chk("midrst_rvalid1_l1", rvalid1_a, 1'b0);
        chk("midrst_rvalid1_l3", rvalid1_b, 1'b0);
        chk("midrst_ptr", ptr_a, 1'b0);
        @(posedge clka);
        #1;
        rst = 1'b1;
        step(1, 0, 16'h1007);
        drive(0, 0, 8'h00, 16'h0000, 1, 0, 8'h05, 16'h0000);
        step(0, 1, 16'h1005);
        idle(6);

        chk("queue_drained", exp1_q.size() + exp3_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
